uart_rx_buffered: RTL and testbench

Parametrised successor to the single-frame UART receive path. It combines a configurable-oversampling RX deserialiser, a 4-bit register interface for frame configuration and status, and a receive FIFO with ready/valid read-out and per-frame error tags. It sits between the Rx pin and the display/command logic, replacing the unbuffered frame + frame_valid output.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_buffered_if.sv | 21 ++
 rtl/uart_rx_fifo.sv | 36 +++
 rtl/uart_rx_buffered.sv | 123 ++++++++++++
 tb/tb_uart_rx_buffered.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: register map, FSM states, reset defaults and error-tag indices for the buffered UART receiver
package uart_pkg;
  localparam logic [3:0] ADDR_PARITY = 4'd0;
  localparam logic [3:0] ADDR_PTYPE  = 4'd1;
  localparam logic [3:0] ADDR_STOP   = 4'd2;
  localparam logic [3:0] ADDR_LEN    = 4'd3;
  localparam logic [3:0] ADDR_STATUS = 4'd4;
  localparam logic [3:0] ADDR_LEN_RD = 4'd5;
  localparam logic [3:0] ADDR_COUNT  = 4'd6;
  localparam logic [3:0] ADDR_ERR    = 4'd7;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  localparam logic       RST_PARITY = 1'b0;
  localparam logic       RST_PTYPE  = 1'b0;
  localparam logic       RST_STOP   = 1'b0;
  localparam logic [3:0] RST_LEN    = 4'd8;
  localparam int ERR_PARITY  = 0;
  localparam int ERR_FRAMING = 1;
endpackage

// File: rtl/uart_rx_buffered_if.sv
// uart_rx_buffered_if: register access bus plus receive-frame stream of the buffered UART receiver
interface uart_rx_buffered_if #(parameter int MAX_DATA_W = 9);
  logic                  valid;
  logic [3:0]            address;
  logic [3:0]            data;
  logic                  ack;
  logic [3:0]            data_out;
  logic [MAX_DATA_W-1:0] frame;
  logic [1:0]            frame_err;
  logic                  frame_valid;
  logic                  frame_ready;
  logic                  overflow;
  modport master (
    output valid, address, data, frame_ready,
    input  ack, data_out, frame, frame_err, frame_valid, overflow
  );
  modport slave (
    input  valid, address, data, frame_ready,
    output ack, data_out, frame, frame_err, frame_valid, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO; a push while full succeeds only if a pop frees the slot in the same cycle
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  input  logic                     pop,
  output logic                     empty,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign wr    = push && (!full || pop);
  assign rd    = pop && !empty;
  assign rdata = mem[rp[AW-1:0]];
  assign count = wp - rp;
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= wdata;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wr ? wp + 1'b1 : wp;
      rp <= rd ? rp + 1'b1 : rp;
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: oversampling UART deserialiser with a 4-bit register file and a tagged receive FIFO
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int MAX_DATA_W = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_16bd,
  input  logic rst,
  input  logic Rx,
  uart_rx_buffered_if.slave bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int W  = MAX_DATA_W + 2;
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0] LEN_MAX = 4'(MAX_DATA_W);
  localparam logic [3:0] LEN_RST = RST_LEN > LEN_MAX ? LEN_MAX : RST_LEN;
  state_t st;
  logic rx_s1, rx_s2, rx_prev, mid, fe_now;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx, c_len, r_len;
  logic [MAX_DATA_W-1:0] sh;
  logic c_par, c_type, c_stop, perr, ferr, stop_idx;
  logic r_par, r_type, r_stop, ovf, ack, acc;
  logic [3:0] data_out, rd_data, cnt_sat;
  logic push, pop, full, empty;
  logic [W-1:0] push_data, rdata;
  logic [AW:0] count;
  assign mid    = cnt == LAST;
  assign fe_now = ferr | ~rx_s2;
  always_ff @(posedge clk_16bd)
    if (rst) begin
      {rx_s1, rx_s2, rx_prev} <= 3'b111;
      st <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      {c_par, c_type, c_stop, perr, ferr, stop_idx, push} <= '0;
      c_len <= LEN_RST;
      push_data <= '0;
    end else begin
      {rx_prev, rx_s2, rx_s1} <= {rx_s2, rx_s1, Rx};
      push <= 1'b0;
      cnt <= mid ? '0 : cnt + 1'b1;
      case (st)
        IDLE: if (rx_prev && !rx_s2) begin
          st <= START;
          cnt <= '0;
        end
        START: if (cnt == HALF) begin
          st <= rx_s2 ? IDLE : DATA;
          cnt <= '0;
          bit_idx <= '0;
          sh <= '0;
          {perr, ferr, stop_idx} <= '0;
          {c_par, c_type, c_stop, c_len} <= {r_par, r_type, r_stop, r_len};
        end
        DATA: if (mid) begin
          sh <= sh | (MAX_DATA_W'(rx_s2) << bit_idx);
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == c_len - 4'd1) st <= c_par ? PARITY : STOP;
        end
        PARITY: if (mid) begin
          perr <= (^sh ^ rx_s2) != c_type;
          st <= STOP;
        end
        STOP: if (mid) begin
          ferr <= fe_now;
          stop_idx <= 1'b1;
          if (stop_idx == c_stop) begin
            push <= 1'b1;
            push_data <= {fe_now, perr, sh};
            st <= fe_now ? BREAK : IDLE;
          end
        end
        BREAK: if (rx_s2) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  assign pop = bus.frame_ready && !empty;
  uart_rx_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_16bd), .rst(rst), .push(push), .wdata(push_data), .full(full),
    .pop(pop), .empty(empty), .rdata(rdata), .count(count)
  );
  if (AW + 1 > 4) begin : g_sat
    assign cnt_sat = count > (AW + 1)'(15) ? 4'hF : count[3:0];
  end else begin : g_nosat
    assign cnt_sat = 4'(count);
  end
  assign bus.frame       = empty ? '0 : rdata[MAX_DATA_W-1:0];
  assign bus.frame_err   = empty ? '0 : {rdata[MAX_DATA_W+ERR_FRAMING], rdata[MAX_DATA_W+ERR_PARITY]};
  assign bus.frame_valid = !empty;
  assign bus.overflow    = ovf;
  assign bus.ack         = ack;
  assign bus.data_out    = data_out;
  assign acc = bus.valid && !ack;
  always_comb
    rd_data = bus.address == ADDR_STATUS ? {r_par, r_type, r_stop, ovf} :
              bus.address == ADDR_LEN_RD ? r_len :
              bus.address == ADDR_COUNT  ? cnt_sat :
              bus.address == ADDR_ERR    ? {2'b00, bus.frame_err} : 4'h0;
  always_ff @(posedge clk_16bd)
    if (rst) begin
      ack <= 1'b0;
      data_out <= '0;
      {r_par, r_type, r_stop} <= {RST_PARITY, RST_PTYPE, RST_STOP};
      r_len <= LEN_RST;
      ovf <= 1'b0;
    end else begin
      ack <= acc;
      data_out <= acc ? rd_data : '0;
      r_par  <= acc && bus.address == ADDR_PARITY ? bus.data[0] : r_par;
      r_type <= acc && bus.address == ADDR_PTYPE  ? bus.data[0] : r_type;
      r_stop <= acc && bus.address == ADDR_STOP   ? bus.data[0] : r_stop;
      r_len  <= acc && bus.address == ADDR_LEN && bus.data >= 4'd5 ?
                (bus.data > LEN_MAX ? LEN_MAX : bus.data) : r_len;
      // a dropped frame outranks a same-cycle clear so it is never lost
      ovf <= (push && full && !bus.frame_ready) | (ovf & ~(acc && bus.address == ADDR_ERR));
    end
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed self-checking bench for the buffered UART receiver
module tb_uart_rx_buffered;
  logic clk = 1'b0;
  logic rst, Rx;
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] rv;
  uart_rx_buffered_if #(.MAX_DATA_W(9)) bus ();
  uart_rx_buffered #(.MAX_DATA_W(9), .FIFO_DEPTH(8), .OVERSAMPLE(16)) dut (
    .clk_16bd(clk), .rst(rst), .Rx(Rx), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int len);
    for (int i = 0; i < len; i++) begin
      Rx = v[i];
      tick(16);
    end
  endtask

  task automatic reg_wr(input logic [3:0] a, input logic [3:0] d);
    bus.valid = 1'b1;
    bus.address = a;
    bus.data = d;
    tick(1);
    bus.valid = 1'b0;
    tick(1);
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [3:0] d);
    bus.valid = 1'b1;
    bus.address = a;
    tick(1);
    chk("rd_ack", 16'(bus.ack), 16'h1);
    d = bus.data_out;
    bus.valid = 1'b0;
    tick(1);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 64 && !bus.frame_valid; i++) tick(1);
    chk(tag, 16'(bus.frame_valid), 16'h1);
  endtask

  task automatic pop1;
    bus.frame_ready = 1'b1;
    tick(1);
    bus.frame_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    Rx = 1'b1;
    bus.valid = 1'b0;
    bus.address = '0;
    bus.data = '0;
    bus.frame_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk("rst_ack", 16'(bus.ack), 16'h0);
    chk("rst_data_out", 16'(bus.data_out), 16'h0);
    chk("rst_valid", 16'(bus.frame_valid), 16'h0);
    chk("rst_frame", 16'(bus.frame), 16'h0);
    chk("rst_err", 16'(bus.frame_err), 16'h0);
    chk("rst_ovf", 16'(bus.overflow), 16'h0);
    reg_rd(4'd4, rv); chk("rst_status", 16'(rv), 16'h0);
    reg_rd(4'd5, rv); chk("rst_len", 16'(rv), 16'h8);

    send_bits({1'b1, 8'hA5, 1'b0}, 10);
    wait_valid("a5_valid");
    chk("a5_frame", 16'(bus.frame), 16'h0A5);
    chk("a5_err", 16'(bus.frame_err), 16'h0);
    pop1();
    chk("a5_popped", 16'(bus.frame_valid), 16'h0);

    reg_wr(4'd3, 4'd9);
    reg_wr(4'd0, 4'd1);
    reg_wr(4'd1, 4'd1);
    reg_rd(4'd4, rv); chk("cfg_status", 16'(rv), 16'hC);
    reg_rd(4'd5, rv); chk("cfg_len9", 16'(rv), 16'h9);
    send_bits({1'b1, 1'b0, 9'h1C3, 1'b0}, 12);
    wait_valid("odd_ok_valid");
    chk("odd_ok_frame", 16'(bus.frame), 16'h1C3);
    chk("odd_ok_err", 16'(bus.frame_err), 16'h0);
    pop1();
    send_bits({1'b1, 1'b1, 9'h1C3, 1'b0}, 12);
    wait_valid("odd_bad_valid");
    chk("odd_bad_frame", 16'(bus.frame), 16'h1C3);
    chk("odd_bad_err", 16'(bus.frame_err), 16'h1);
    reg_rd(4'd7, rv); chk("odd_bad_rd7", 16'(rv), 16'h1);
    pop1();
    reg_wr(4'd3, 4'd8);
    reg_wr(4'd0, 4'd0);
    reg_wr(4'd1, 4'd0);

    send_bits({1'b0, 8'h55, 1'b0}, 10);
    tick(48);
    reg_rd(4'd6, rv); chk("brk_count", 16'(rv), 16'h1);
    chk("brk_frame", 16'(bus.frame), 16'h055);
    chk("brk_err", 16'(bus.frame_err), 16'h2);
    Rx = 1'b1;
    tick(32);
    reg_rd(4'd6, rv); chk("brk_count_after", 16'(rv), 16'h1);
    pop1();

    Rx = 1'b0;
    tick(4);
    Rx = 1'b1;
    tick(40);
    chk("glitch_valid", 16'(bus.frame_valid), 16'h0);
    reg_rd(4'd6, rv); chk("glitch_count", 16'(rv), 16'h0);
    send_bits({1'b1, 8'h3C, 1'b0}, 10);
    wait_valid("post_glitch_valid");
    chk("post_glitch_frame", 16'(bus.frame), 16'h03C);
    pop1();

    for (int i = 0; i < 9; i++) send_bits({1'b1, 8'(8'h10 + i), 1'b0}, 10);
    tick(4);
    reg_rd(4'd6, rv); chk("ovf_count", 16'(rv), 16'h8);
    reg_rd(4'd4, rv); chk("ovf_status", 16'(rv), 16'h1);
    chk("ovf_flag", 16'(bus.overflow), 16'h1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_pop%0d", i), 16'(bus.frame), 16'(16'h10 + i));
      pop1();
    end
    chk("ovf_drained", 16'(bus.frame_valid), 16'h0);
    reg_rd(4'd7, rv); chk("ovf_rd7", 16'(rv), 16'h0);
    chk("ovf_cleared", 16'(bus.overflow), 16'h0);

    reg_wr(4'd3, 4'd3);
    reg_rd(4'd5, rv); chk("len_ignored", 16'(rv), 16'h8);
    reg_wr(4'd3, 4'd15);
    reg_rd(4'd5, rv); chk("len_clamped", 16'(rv), 16'h9);
    reg_wr(4'd3, 4'd8);
    fork
      send_bits({2'b11, 8'h3C, 1'b0, 1'b1, 8'h5A, 1'b0}, 21);
      begin
        tick(40);
        reg_wr(4'd2, 4'd1);
      end
    join
    reg_rd(4'd4, rv); chk("stop2_status", 16'(rv), 16'h2);
    wait_valid("stop_a_valid");
    chk("stop_a_frame", 16'(bus.frame), 16'h05A);
    chk("stop_a_err", 16'(bus.frame_err), 16'h0);
    pop1();
    wait_valid("stop_b_valid");
    chk("stop_b_frame", 16'(bus.frame), 16'h03C);
    chk("stop_b_err", 16'(bus.frame_err), 16'h0);
    pop1();
    chk("final_empty", 16'(bus.frame_valid), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
